// File: rtl/vblank_update_arbiter.sv
// vblank_update_arbiter
// ---------------------------------------------------------------------------
// Purpose: shares one display-side update port (palette / sprite-register
// writes) among NUM_REQ requesters. A grant is only issued, and only kept,
// while the vertical-blanking window is open. The window closes GUARD pixels
// before the frame wraps, so an update never spills into visible pixels.
// Requesters are served round-robin, one owner at a time, and each grant is
// limited to MAX_HOLD cycles.
//
// Handshake: req[i] is a level. It stays high for as long as requester i wants
// the port. gnt is one-hot and registered; gnt[i] high means requester i owns
// the port during that cycle. The owner ends its tenure by pulsing done[i] for
// one cycle or by dropping req[i]. The arbiter can also take the grant away:
// it pulses abort when the window closes and timeout when MAX_HOLD expires.
// Both pulses coincide with the first cycle in which gnt is low. done and req
// on bits other than the owner's are ignored.
//
// Ports:
//   pclk         in   pixel clock, rising edge
//   reset        in   synchronous, active-high
//   vblnk        in   vertical blank from the timing generator
//   vcount       in   current line
//   hcount       in   current pixel
//   req          in   per-requester request level
//   done         in   per-requester completion pulse (owner bit only)
//   gnt          out  one-hot registered grant
//   gnt_id       out  index of the current / last owner
//   busy         out  high while any gnt bit is high
//   window       out  registered grant window
//   timeout      out  one-cycle pulse on MAX_HOLD revocation
//   abort        out  one-cycle pulse on guard-band revocation
//   dbg_state_o  out  FSM state (0 idle, 1 grant, 2 release)
// ---------------------------------------------------------------------------
module vblank_update_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int MAX_HOLD  = 256,
  parameter int GUARD     = 16,
  parameter int HOR_TOTAL = 1056,
  parameter int VER_TOTAL = 628
) (
  input  logic                       pclk,
  input  logic                       reset,
  input  logic                       vblnk,
  input  logic [10:0]                vcount,
  input  logic [10:0]                hcount,
  input  logic [NUM_REQ-1:0]         req,
  input  logic [NUM_REQ-1:0]         done,
  output logic [NUM_REQ-1:0]         gnt,
  output logic [$clog2(NUM_REQ)-1:0] gnt_id,
  output logic                       busy,
  output logic                       window,
  output logic                       timeout,
  output logic                       abort,
  output logic [1:0]                 dbg_state_o
);

  localparam int ID_W   = $clog2(NUM_REQ);
  localparam int HOLD_W = $clog2(MAX_HOLD + 1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_GRANT   = 2'd1,
    S_RELEASE = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [NUM_REQ-1:0]  gnt_q, gnt_d;
  logic [ID_W-1:0]     gnt_id_q, gnt_id_d;
  logic [ID_W-1:0]     ptr_q, ptr_d;
  logic [HOLD_W-1:0]   hold_q, hold_d;
  logic                busy_q;
  logic                window_q;
  logic                timeout_q, timeout_d;
  logic                abort_q, abort_d;

  // The window closes GUARD pixels before the end of the last line of the
  // frame. That leaves the owner time to stop before the frame wraps.
  logic window_c;
  assign window_c = vblnk &&
                    !((vcount == 11'(VER_TOTAL - 1)) &&
                      (hcount >= 11'(HOR_TOTAL - GUARD)));

  // Round-robin search. Start at ptr_q and wrap; the first set request wins.
  logic            win_found;
  logic [ID_W-1:0] win_idx;
  logic [ID_W-1:0] scan_idx;
  int              scan_pos;

  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    scan_idx  = '0;
    scan_pos  = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
      scan_pos = int'(ptr_q) + i;
      if (scan_pos >= NUM_REQ) scan_pos = scan_pos - NUM_REQ;
      scan_idx = ID_W'(scan_pos);
      if (!win_found && req[scan_idx]) begin
        win_found = 1'b1;
        win_idx   = scan_idx;
      end
    end
  end

  logic [ID_W-1:0] ptr_next;
  assign ptr_next = (gnt_id_q == ID_W'(NUM_REQ - 1)) ? '0 : gnt_id_q + 1'b1;

  logic owner_end;
  assign owner_end = done[gnt_id_q] || !req[gnt_id_q];

  always_comb begin
    state_d   = state_q;
    gnt_d     = gnt_q;
    gnt_id_d  = gnt_id_q;
    ptr_d     = ptr_q;
    hold_d    = hold_q;
    timeout_d = 1'b0;
    abort_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        gnt_d = '0;
        if (window_c && win_found) begin
          gnt_d    = {{(NUM_REQ-1){1'b0}}, 1'b1} << win_idx;
          gnt_id_d = win_idx;
          hold_d   = '0;
          state_d  = S_GRANT;
        end
      end
      S_GRANT: begin
        hold_d = hold_q + HOLD_W'(1);
        if (owner_end || !window_c || (hold_q == HOLD_W'(MAX_HOLD - 1))) begin
          gnt_d   = '0;
          ptr_d   = ptr_next;
          state_d = S_RELEASE;
          // A normal end takes precedence and raises no pulse. If the window
          // closes in the same cycle the hold limit expires, abort wins.
          if (!owner_end) begin
            if (!window_c) abort_d   = 1'b1;
            else           timeout_d = 1'b1;
          end
        end
      end
      S_RELEASE: begin
        gnt_d   = '0;
        state_d = S_IDLE;
      end
      default: begin
        gnt_d   = '0;
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge pclk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      gnt_q     <= '0;
      gnt_id_q  <= '0;
      ptr_q     <= '0;
      hold_q    <= '0;
      busy_q    <= 1'b0;
      window_q  <= 1'b0;
      timeout_q <= 1'b0;
      abort_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      gnt_q     <= gnt_d;
      gnt_id_q  <= gnt_id_d;
      ptr_q     <= ptr_d;
      hold_q    <= hold_d;
      busy_q    <= |gnt_d;
      window_q  <= window_c;
      timeout_q <= timeout_d;
      abort_q   <= abort_d;
    end
  end

  assign gnt         = gnt_q;
  assign gnt_id      = gnt_id_q;
  assign busy        = busy_q;
  assign window      = window_q;
  assign timeout     = timeout_q;
  assign abort       = abort_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_vblank_update_arbiter.sv
// Bench for vblank_update_arbiter. A behavioural model of the ownership rules
// predicts every output after every clock edge. Directed scenarios pin the
// behaviour with literal values, and a randomized phase follows.
module tb_vblank_update_arbiter;

  localparam int NUM_REQ   = 4;
  localparam int MAX_HOLD  = 256;
  localparam int GUARD     = 16;
  localparam int HOR_TOTAL = 1056;
  localparam int VER_TOTAL = 628;

  // ---------------- clock / reset ----------------
  logic        pclk = 1'b0;
  logic        reset = 1'b1;
  logic        vblnk = 1'b0;
  logic [10:0] vcount = '0;
  logic [10:0] hcount = '0;
  logic [3:0]  req = '0;
  logic [3:0]  done = '0;
  logic [3:0]  gnt;
  logic [1:0]  gnt_id;
  logic        busy, window, timeout, abort;
  logic [1:0]  dbg_state;

  always #5 pclk = ~pclk;

  vblank_update_arbiter #(
    .NUM_REQ(NUM_REQ), .MAX_HOLD(MAX_HOLD), .GUARD(GUARD),
    .HOR_TOTAL(HOR_TOTAL), .VER_TOTAL(VER_TOTAL)
  ) dut (
    .pclk(pclk), .reset(reset), .vblnk(vblnk), .vcount(vcount),
    .hcount(hcount), .req(req), .done(done), .gnt(gnt), .gnt_id(gnt_id),
    .busy(busy), .window(window), .timeout(timeout), .abort(abort),
    .dbg_state_o(dbg_state)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // owner -1 means nobody holds the port. held counts the grant cycles that
  // have completed. dead marks the mandatory gap cycle that follows a grant.
  int  m_owner = -1;
  int  m_held  = 0;
  int  m_ptr   = 0;
  int  m_last  = 0;
  bit  m_dead  = 0;
  bit  m_win   = 0;
  bit  m_to    = 0;
  bit  m_ab    = 0;
  logic [9:0] exp_q[$];

  task automatic model_step();
    bit win;
    bit ended;
    win   = vblnk && !((int'(vcount) == VER_TOTAL - 1) && (int'(hcount) >= HOR_TOTAL - GUARD));
    m_to  = 0;
    m_ab  = 0;
    ended = 0;
    if (reset) begin
      m_owner = -1; m_held = 0; m_ptr = 0; m_last = 0; m_dead = 0; m_win = 0;
    end else begin
      m_win = win;
      if (m_owner >= 0) begin
        m_held++;
        if (done[m_owner] || !req[m_owner]) ended = 1;
        else if (!win) begin ended = 1; m_ab = 1; end
        else if (m_held == MAX_HOLD) begin ended = 1; m_to = 1; end
        if (ended) begin
          m_ptr   = (m_owner + 1) % NUM_REQ;
          m_owner = -1;
          m_dead  = 1;
        end
      end else if (m_dead) begin
        m_dead = 0;
      end else if (win && req != 0) begin
        for (int k = 0; k < NUM_REQ; k++) begin
          if (m_owner < 0 && req[(m_ptr + k) % NUM_REQ]) m_owner = (m_ptr + k) % NUM_REQ;
        end
        m_held = 0;
        m_last = m_owner;
      end
    end
    exp_q.push_back({(m_owner >= 0) ? 4'(1 << m_owner) : 4'd0, 2'(m_last),
                     (m_owner >= 0), m_win, m_to, m_ab});
  endtask

  // ---------------- scoreboard / monitor ----------------
  int id_log[$];
  int len_log[$];
  int gap_log[$];
  int n_rise = 0, n_to = 0, n_ab = 0;
  int hi_len = 0, lo_len = 0;
  logic [3:0] prev_gnt = '0;

  task automatic compare();
    logic [9:0] e;
    if (exp_q.size() == 0) begin
      chk("exp_q_empty", 1, 0);
      return;
    end
    e = exp_q.pop_front();
    chk("gnt", gnt, e[9:6]);
    chk("gnt_id", gnt_id, e[5:4]);
    chk("busy", busy, e[3]);
    chk("window", window, e[2]);
    chk("timeout", timeout, e[1]);
    chk("abort", abort, e[0]);
    if (gnt != 0) begin
      if (prev_gnt == 0) begin
        id_log.push_back(int'(gnt_id));
        gap_log.push_back(lo_len);
        n_rise++;
        hi_len = 0;
      end
      hi_len++;
    end else begin
      if (prev_gnt != 0) begin
        len_log.push_back(hi_len);
        lo_len = 0;
      end
      lo_len++;
    end
    if (timeout === 1'b1) n_to++;
    if (abort === 1'b1) n_ab++;
    prev_gnt = gnt;
  endtask

  initial begin
    forever begin
      @(posedge pclk);
      model_step();
      #1;
      compare();
    end
  end

  task automatic clear_logs();
    id_log.delete(); len_log.delete(); gap_log.delete();
    n_rise = 0; n_to = 0; n_ab = 0;
  endtask

  // ---------------- driver tasks ----------------
  task automatic step();
    @(negedge pclk);
    done = '0;
  endtask

  task automatic do_reset();
    step();
    reset = 1'b1; req = '0; vblnk = 1'b0; vcount = 11'd100; hcount = '0;
    step();
    step();
    reset = 1'b0;
  endtask

  task automatic wait_owner(input int budget);
    int n;
    n = 0;
    while (m_owner < 0 && n < budget) begin
      step();
      n++;
    end
    chk("wait_grant", (m_owner >= 0), 1);
  endtask

  task automatic get_or(input int q_idx, input int which, output int v);
    v = -1;
    case (which)
      0: if (id_log.size() > q_idx)  v = id_log[q_idx];
      1: if (len_log.size() > q_idx) v = len_log[q_idx];
      default: if (gap_log.size() > q_idx) v = gap_log[q_idx];
    endcase
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    int v;
    int exp_order[5];
    exp_order = '{0, 1, 2, 3, 0};

    // Reset state, then a held request while vblnk is low.
    do_reset();
    chk("rst_gnt", gnt, 0);
    chk("rst_gnt_id", gnt_id, 0);
    chk("rst_busy", busy, 0);
    chk("rst_window", window, 0);
    chk("rst_timeout", timeout, 0);
    chk("rst_abort", abort, 0);
    chk("rst_state", dbg_state, 0);
    req = 4'b0001; vblnk = 1'b0; vcount = 11'd100;
    clear_logs();
    repeat (10) step();
    chk("no_gnt_vblnk0", n_rise, 0);
    vblnk = 1'b1; vcount = 11'd600; hcount = '0;
    step();
    chk("first_gnt", gnt, 4'b0001);
    chk("first_window", window, 1);

    // Round-robin across all four requesters.
    do_reset();
    vblnk = 1'b1; vcount = 11'd600; hcount = '0; req = 4'b1111;
    clear_logs();
    for (int g = 0; g < 5; g++) begin
      int o;
      wait_owner(10);
      o = m_owner;
      step();
      step();
      if (o >= 0) done = 4'(1 << o);
      step();
    end
    repeat (3) step();
    for (int g = 0; g < 5; g++) begin
      get_or(g, 0, v);
      chk($sformatf("rr_order%0d", g), v, exp_order[g]);
    end
    for (int g = 1; g < 5; g++) begin
      get_or(g, 2, v);
      chk($sformatf("rr_gap%0d", g), v, 2);
    end

    // Hold limit on a lone requester that never finishes.
    do_reset();
    vblnk = 1'b1; vcount = 11'd600; req = 4'b0010;
    clear_logs();
    repeat (300) step();
    get_or(0, 1, v);
    chk("to_len", v, MAX_HOLD);
    chk("to_pulses", n_to, 1);
    chk("to_aborts", n_ab, 0);
    get_or(1, 0, v);
    chk("to_regrant_id", v, 1);

    // Guard band at the end of the last line.
    do_reset();
    vblnk = 1'b1; vcount = 11'(VER_TOTAL - 1); hcount = 11'd1030; req = 4'b0001;
    clear_logs();
    step();
    for (int h = 1031; h < HOR_TOTAL; h++) begin
      hcount = 11'(h);
      step();
    end
    vblnk = 1'b0; vcount = '0; hcount = '0;
    repeat (20) step();
    chk("guard_aborts", n_ab, 1);
    chk("guard_timeouts", n_to, 0);
    chk("guard_grants", n_rise, 1);
    get_or(0, 1, v);
    chk("guard_len", v, 10);
    vblnk = 1'b1; vcount = 11'd600;
    step();
    step();
    chk("guard_resume", n_rise, 2);

    // done arrives in the cycle the hold limit would expire.
    do_reset();
    vblnk = 1'b1; vcount = 11'd600; hcount = '0; req = 4'b0001;
    clear_logs();
    wait_owner(10);
    for (int n = 0; n < 300; n++) begin
      if (m_owner >= 0 && m_held == MAX_HOLD - 1) begin
        done = 4'b0001;
        break;
      end
      step();
    end
    repeat (4) step();
    get_or(0, 1, v);
    chk("done_to_len", v, MAX_HOLD);
    chk("done_to_timeouts", n_to, 0);
    chk("done_to_aborts", n_ab, 0);

    // Reset in the middle of a grant.
    do_reset();
    vblnk = 1'b1; vcount = 11'd600; req = 4'b0100;
    wait_owner(10);
    repeat (5) step();
    chk("pre_rst_gnt", gnt, 4'b0100);
    reset = 1'b1;
    step();
    chk("mid_rst_gnt", gnt, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_gnt_id", gnt_id, 0);
    reset = 1'b0; req = 4'b1000;
    step();
    chk("post_rst_gnt", gnt, 4'b1000);
    chk("post_rst_gnt_id", gnt_id, 3);

    // Randomized phase, alternating noisy and quiet stretches.
    do_reset();
    vblnk = 1'b1; vcount = 11'd600; hcount = 11'($urandom_range(0, HOR_TOTAL - 1));
    for (int n = 0; n < 4000; n++) begin
      bit quiet;
      quiet = ((n / 500) % 2) == 1;
      reset = ($urandom_range(0, 1499) == 0);
      if ($urandom_range(0, 99) == 0) vblnk = ~vblnk;
      if (int'(hcount) >= HOR_TOTAL - 1) begin
        hcount = '0;
        vcount = ($urandom_range(0, 1) == 1) ? 11'(VER_TOTAL - 1) : 11'd600;
      end else begin
        hcount = hcount + 11'd1;
      end
      if ($urandom_range(0, 199) == 0) begin
        hcount = 11'($urandom_range(1000, HOR_TOTAL - 1));
        vcount = ($urandom_range(0, 1) == 1) ? 11'(VER_TOTAL - 1) : 11'd600;
      end
      if ($urandom_range(0, quiet ? 400 : 24) == 0) req = 4'($urandom_range(0, 15));
      if (!quiet) begin
        if (m_owner >= 0 && $urandom_range(0, 39) == 0) done = 4'(1 << m_owner);
        else if ($urandom_range(0, 9) == 0) done = 4'($urandom_range(0, 15));
      end
      step();
    end
    reset = 1'b0;
    repeat (4) step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/vblank_update_arbiter.md
Name: vblank_update_arbiter

Overview:
- Shares one display-side update port (palette/sprite-register writes) among NUM_REQ requesters.
- Issues grants only inside the vertical-blanking window produced by the 800x600@60 timing generator, so updates never tear visible pixels.
- Round-robin, one owner at a time, with per-grant hold limit and guard band before frame wrap.
- Sits between the timing generator outputs and the per-feature update engines.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
MAX_HOLD, 256, max cycles a single grant may be held
GUARD, 16, cycles before frame wrap in which grants are revoked/not issued (1..HOR_TOTAL-1)
HOR_TOTAL, 1056, pixels per line incl. blanking
VER_TOTAL, 628, lines per frame incl. blanking

Ports:
pclk  in  1  pixel clock, all logic on rising edge
reset  in  1  synchronous, active-high
vblnk  in  1  vertical blank from timing generator
vcount  in  11  current line
hcount  in  11  current pixel
req  in  NUM_REQ  request, level, one bit per requester
done  in  NUM_REQ  owner finished, single-cycle pulse
gnt  out  NUM_REQ  one-hot grant, registered
gnt_id  out  clog2(NUM_REQ)  index of current/last owner
busy  out  1  high while any gnt bit is high
window  out  1  registered copy of window_c
timeout  out  1  one-cycle pulse on forced MAX_HOLD revocation
abort  out  1  one-cycle pulse on guard-band revocation

Behaviour:
- One clock (pclk); synchronous active-high reset; reset values: gnt=0, gnt_id=0, busy=0, window=0, timeout=0, abort=0, FSM=IDLE, rr pointer=0, hold counter=0. Reset mid-grant drops gnt on the next edge, no pulses.
- window_c (combinational) = vblnk AND NOT (vcount==VER_TOTAL-1 AND hcount>=HOR_TOTAL-GUARD). window <= window_c each cycle.
- Round-robin: search req starting at index ptr, wrapping modulo NUM_REQ; first set bit wins. ptr <= winner+1 (mod NUM_REQ) when the grant ends.
- FSM states IDLE, GRANT, RELEASE.
- IDLE: if window_c and |req: gnt <= onehot(winner), gnt_id <= winner, hold <= 0, -> GRANT. Latency req->gnt = 1 cycle. Else stay, gnt=0.
- GRANT: hold increments each cycle. Exit priority, evaluated per cycle:
  1) done[gnt_id]==1 or req[gnt_id]==0 -> normal end.
  2) window_c==0 -> abort pulse.
  3) hold==MAX_HOLD-1 -> timeout pulse.
  Any exit: gnt <= 0, -> RELEASE. gnt is high for at most MAX_HOLD cycles.
- done/req on non-owner bits are ignored during GRANT. done in IDLE/RELEASE is ignored.
- Simultaneous events: done with window close or timeout counts as a normal end, no pulse. Window close with timeout gives abort only.
- RELEASE: one mandatory dead cycle, gnt=0. Then -> IDLE; next grant is no earlier than 2 cycles after gnt falls.
- busy = |gnt, registered with gnt. gnt_id holds its value after release.
- timeout/abort are high exactly one cycle, coincident with the first gnt=0 cycle.
- No grant is issued while vblnk=0, regardless of req.

Test Plan:
- Reset, then req=4'b0001 held with vblnk=0 (vcount=100) -> gnt stays 0. vblnk->1 at vcount=600, hcount=0 -> gnt=0001 on next edge, window=1.
- req=4'b1111, each owner pulses done 3 cycles after its grant -> grant order 0,1,2,3,0; 1 dead cycle between grants; gnt_id follows.
- Single req=0010, never done, window open -> gnt high exactly 256 cycles; timeout=1 for one cycle as gnt falls; after dead cycle, requester 1 regranted (only requester).
- Grant active at vcount=627, hcount reaching 1040 (HOR_TOTAL-GUARD) -> gnt falls next edge with abort=1. No new grant until the next vblnk, even with req held.
- done and timeout in the same cycle (done at hold=255) -> gnt drops, timeout=0, abort=0.
- Assert reset mid-grant -> next edge gnt=0, busy=0, gnt_id=0. Then req=1000 -> first grant uses ptr=0 search, gnt=1000.
